// File: rtl/param_serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The controller drives the operands and start; the subtractor returns the status and the result.
interface param_serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/param_serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, one bit per clock.
// The result register and the borrow output only update when the last bit has been processed.
module param_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  param_serial_subtractor_if.slave sub_if
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    bitCnt_q;
  logic             borrowIn_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;

  logic             diffBit_d;
  logic             borrowBit_d;
  logic             lastBit_d;
  logic [WIDTH-1:0] result_d;

  always_comb begin
    diffBit_d   = opA_q[0] ^ opB_q[0] ^ borrowIn_q;
    borrowBit_d = (~opA_q[0] & opB_q[0]) | (~(opA_q[0] ^ opB_q[0]) & borrowIn_q);
    // New bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    result_d            = result_q >> 1;
    result_d[WIDTH-1]   = diffBit_d;
    lastBit_d           = (bitCnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      result_q   <= '0;
      diff_q     <= '0;
      bitCnt_q   <= '0;
      borrowIn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      borrow_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          result_q   <= result_d;
          opA_q      <= opA_q >> 1;
          opB_q      <= opB_q >> 1;
          borrowIn_q <= borrowBit_d;
          bitCnt_q   <= bitCnt_q + CW'(1);
          if (lastBit_d) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= result_d;
            borrow_q <= borrowBit_d;
          end
        end
        default: begin
          // IDLE and DONE both accept, which gives back-to-back operation without a bubble.
          if (sub_if.start) begin
            state_q    <= RUN;
            opA_q      <= sub_if.a;
            opB_q      <= sub_if.b;
            result_q   <= '0;
            bitCnt_q   <= '0;
            borrowIn_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign sub_if.busy   = busy_q;
  assign sub_if.done   = done_q;
  assign sub_if.diff   = diff_q;
  assign sub_if.borrow = borrow_q;
endmodule

// File: tb/tb_param_serial_subtractor.sv
// Scoreboard bench for the bit-serial subtractor: expected {borrow,diff} values are queued
// when an operation is issued and compared whenever done pulses.
module tb_param_serial_subtractor;
  localparam int WIDTH      = 4;
  localparam int EDGE_LIMIT = 20;

  logic clk;
  logic rst_n;

  param_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  param_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sub_if (bus)
  );

  int               totalChecks = 0;
  int               badChecks   = 0;
  int               doneCount   = 0;
  logic [WIDTH:0]   sbQueue[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // Issues a one-cycle start pulse; returns just after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                               input bit track);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = opA;
    bus.b     = opB;
    if (track) sbQueue.push_back(model(opA, opB));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int edges, output int busyCycles);
    edges      = 0;
    busyCycles = 0;
    while (!bus.done && edges < EDGE_LIMIT) begin
      if (bus.busy) busyCycles++;
      @(posedge clk);
      #1;
      edges++;
    end
    if (edges >= EDGE_LIMIT) checkOutput("doneTimeout", edges, WIDTH);
  endtask

  task automatic runOp(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB);
    int             edges;
    int             busyCycles;
    logic [WIDTH:0] exp;
    exp = model(opA, opB);
    applyStimulus(opA, opB, 1'b1);
    waitDone(edges, busyCycles);
    checkOutput("latency", edges, WIDTH);
    checkOutput("busyCycles", busyCycles, WIDTH);
    checkOutput("busyAtDone", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("doneOnePulse", bus.done, 0);
    checkOutput("diffHeld", bus.diff, exp[WIDTH-1:0]);
    checkOutput("borrowHeld", bus.borrow, exp[WIDTH]);
  endtask

  always @(negedge clk) begin
    logic [WIDTH:0] exp;
    if (rst_n && bus.done) begin
      doneCount++;
      if (sbQueue.size() == 0) begin
        checkOutput("spuriousDone", 1, 0);
      end else begin
        exp = sbQueue.pop_front();
        checkOutput("sbDiff", bus.diff, exp[WIDTH-1:0]);
        checkOutput("sbBorrow", bus.borrow, exp[WIDTH]);
      end
    end
  end

  initial begin
    int edges;
    int busyCycles;
    int doneBefore;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstDiff", bus.diff, 0);
    checkOutput("rstBorrow", bus.borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp(4'd5, 4'd3);
    runOp(4'd3, 4'd5);
    runOp(4'd0, 4'd1);
    runOp(4'd15, 4'd15);
    runOp(4'd0, 4'd0);
    runOp(4'd15, 4'd0);

    // start held high: the second op is taken straight out of DONE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 4'd2;
    sbQueue.push_back(model(4'd9, 4'd2));
    @(posedge clk);
    #1;
    bus.a = 4'd2;
    bus.b = 4'd9;
    sbQueue.push_back(model(4'd2, 4'd9));
    waitDone(edges, busyCycles);
    checkOutput("b2bFirstLatency", edges, WIDTH);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2bNoBubble", bus.busy, 1);
    waitDone(edges, busyCycles);
    checkOutput("b2bPeriod", edges + 1, WIDTH + 1);
    repeat (3) @(posedge clk);
    #1;

    // start pulsed during RUN with different operands must be ignored.
    applyStimulus(4'd12, 4'd5, 1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    doneBefore = doneCount;
    waitDone(edges, busyCycles);
    checkOutput("midRunLatency", edges, WIDTH - 2);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midRunSingleDone", doneCount, doneBefore + 1);
    checkOutput("midRunDiff", bus.diff, 7);

    // Asynchronous reset two clocks into 6-1 discards the operation.
    applyStimulus(4'd6, 4'd1, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstBusy", bus.busy, 0);
    checkOutput("asyncRstDone", bus.done, 0);
    checkOutput("asyncRstDiff", bus.diff, 0);
    checkOutput("asyncRstBorrow", bus.borrow, 0);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    doneBefore = doneCount;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("postRstNoDone", doneCount, doneBefore);
    checkOutput("postRstIdle", bus.busy, 0);

    runOp(4'd6, 4'd1);
    checkOutput("sbDrained", sbQueue.size(), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got %0t expected completion", $time);
    $fatal(1, "[TB] simulation did not complete");
  end
endmodule
